layer_sched: RTL and testbench
==============================

LAYER_SCHED -- requirements
Module: layer_sched

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  sole clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- slave_waitrequest  out  1  CPU slave stall
- slave_address  in  4  CPU word offset
- slave_read / slave_write  in  1  CPU strobes
- slave_readdata  out  32  CPU read data
- slave_writedata  in  32  CPU write data
- dot_address  out  4  word offset into dot engine slave
- dot_read / dot_write  out  1  dot engine strobes
- dot_writedata  out  32  dot engine write data
- dot_readdata  in  32  dot engine read data, valid the cycle after a read is accepted
- dot_waitrequest  in  1  dot engine stall
- mem_address  out  32  result-store byte address
- mem_write  out  1  result-store strobe
- mem_writedata  out  32  result value
- mem_waitrequest  in  1  memory stall

REQ-002 The CPU word-offset map SHALL be:
- 0: write starts the layer; read stalls until DONE, then returns the count of results written
- 2: weight matrix base
- 3: input vector address
- 4: output vector base
- 5: input length N
- 6: output count M
- 1 and 7: reserved; read 0, write ignored
- Offsets 2–6 read back their stored values.

Function
REQ-003 The FSM SHALL have states IDLE, CFG_W, CFG_V, CFG_L, GO, RES, STORE, NEXT, DONE.
REQ-004 A write to offset 0 in IDLE or DONE SHALL latch offsets 2–6, clear index i and count, and go to CFG_W. If M=0 it SHALL go straight to DONE.
REQ-005 Each configuration state SHALL hold dot_write with the write data below until dot_waitrequest is low, then advance to the next state:
- CFG_W: offset 2, data weight_base + i*N*4
- CFG_V: offset 3, data input_addr
- CFG_L: offset 5, data N
- GO: offset 0, any data
REQ-006 RES SHALL hold dot_read at offset 0 until dot_waitrequest is low, then capture dot_readdata on the following cycle.
REQ-007 If N=0, the block SHALL skip CFG_W..RES for every i and use result 0.
REQ-008 STORE SHALL hold mem_write with mem_address = out_base + i*4 until mem_waitrequest is low, then increment count.
REQ-009 NEXT SHALL increment i and go to CFG_W if i<M, otherwise to DONE.
REQ-010 Address arithmetic SHALL be 32-bit modulo 2^32 with no overflow detection.
REQ-011 slave_waitrequest SHALL be high in every state except IDLE and DONE, and high during reset. Any CPU access while busy therefore stalls.
REQ-012 Slave reads SHALL be answered in the cycle waitrequest is low, with slave_readdata registered.
REQ-013 At most one of dot_read, dot_write, mem_write SHALL be high in any cycle.
REQ-014 A start write in DONE SHALL restart the layer unconditionally, even with unchanged configuration.

Reset
REQ-015 Asserting rst_n low at any time, including mid-layer, SHALL asynchronously force:
- state IDLE
- all strobes 0
- slave_readdata, dot_writedata, mem_writedata, mem_address, i, count, all config registers: 0
- dot_address 0
REQ-016 An interrupted layer SHALL NOT resume after reset; it must be restarted.

Configuration
REQ-017 With LAYER_SCHED_RELU_EN defined, results with bit 31 set SHALL be stored as 0. Without it, results SHALL be stored unmodified.
REQ-018 The count returned at offset 0 SHALL be unaffected by LAYER_SCHED_RELU_EN.

Structure
REQ-019 Package layer_sched_pkg SHALL hold the state enum, the CPU offsets (0, 2–6), and the dot offsets (0, 2, 3, 5).
REQ-020 The block SHALL be a single module with no sub-module; the dot engine is external.

Verification
REQ-021 Basic layer:
- Stimulus: N=2, M=3, weight_base 0x1000, out 0x2000, dot model returns 5,−3,7.
- Required: dot offset-2 writes 0x1000, 0x1008, 0x1010; mem writes 0x2000=5, 0x2004=0xFFFFFFFD, 0x2008=7; offset-0 read returns 3.
REQ-022 Stall handling:
- Stimulus: dot_waitrequest high 4 cycles on each access, mem_waitrequest high 2 cycles.
- Required: identical results; strobes and data held stable throughout each stall.
REQ-023 Edge cases:
- M=0: offset-0 read returns 0 with no dot or mem traffic.
- N=0, M=2: two mem writes of 0 with no dot traffic.
REQ-024 Reset mid-layer:
- Stimulus: rst_n low during STORE of i=1.
- Required: strobes drop immediately; after release a CPU read of offset 5 returns 0 with waitrequest low.
REQ-025 Feature macro:
- Stimulus: dot model returns −4.
- Required: stored 0 with LAYER_SCHED_RELU_EN defined, 0xFFFFFFFC without.
REQ-026 Re-start:
- Stimulus: start written twice with identical configuration.
- Required: the second layer re-issues all dot and mem traffic.

Source files
------------

// File: rtl/layer_sched_pkg.sv
// Shared definitions for the layer scheduler: FSM state codes, CPU register
// offsets, dot-engine register offsets and the optional ReLU clamp.
package layer_sched_pkg;

   typedef logic [3:0] state_t;

   localparam state_t ST_IDLE  = 4'd0;
   localparam state_t ST_CFG_W = 4'd1;
   localparam state_t ST_CFG_V = 4'd2;
   localparam state_t ST_CFG_L = 4'd3;
   localparam state_t ST_GO    = 4'd4;
   localparam state_t ST_RES   = 4'd5;
   localparam state_t ST_STORE = 4'd6;
   localparam state_t ST_NEXT  = 4'd7;
   localparam state_t ST_DONE  = 4'd8;

   localparam logic [3:0] CPU_START  = 4'd0;
   localparam logic [3:0] CPU_WBASE  = 4'd2;
   localparam logic [3:0] CPU_INADDR = 4'd3;
   localparam logic [3:0] CPU_OBASE  = 4'd4;
   localparam logic [3:0] CPU_LEN    = 4'd5;
   localparam logic [3:0] CPU_OUTCNT = 4'd6;

   localparam logic [3:0] DOT_CTRL  = 4'd0;
   localparam logic [3:0] DOT_WBASE = 4'd2;
   localparam logic [3:0] DOT_VEC   = 4'd3;
   localparam logic [3:0] DOT_LEN   = 4'd5;

   function automatic logic [31:0] relu(input logic [31:0] v);
      return v[31] ? '0 : v;
   endfunction

endpackage

// File: rtl/layer_sched.sv
// Layer scheduler: drives an external dot-product engine row by row and stores
// each result to memory. Define LAYER_SCHED_RELU_EN to clamp negative results to 0.
module layer_sched
   import layer_sched_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   output logic        slave_waitrequest,
   input  logic [3:0]  slave_address,
   input  logic        slave_read,
   input  logic        slave_write,
   output logic [31:0] slave_readdata,
   input  logic [31:0] slave_writedata,
   output logic [3:0]  dot_address,
   output logic        dot_read,
   output logic        dot_write,
   output logic [31:0] dot_writedata,
   input  logic [31:0] dot_readdata,
   input  logic        dot_waitrequest,
   output logic [31:0] mem_address,
   output logic        mem_write,
   output logic [31:0] mem_writedata,
   input  logic        mem_waitrequest
);

   state_t      state_q, state_d;
   logic [31:0] wbase_q, wbase_d, inaddr_q, inaddr_d, obase_q, obase_d;
   logic [31:0] len_q, len_d, outcnt_q, outcnt_d;
   logic [31:0] idx_q, idx_d, count_q, count_d;
   logic [31:0] rowaddr_q, rowaddr_d, memaddr_q, memaddr_d;
   logic [31:0] result_q, result_d, rdata_q, rdata_d;
   logic        rdpend_q, rdpend_d;
   logic        host_ok;
   logic [31:0] idx_nxt;

   assign host_ok           = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign slave_waitrequest = ~rst_n | ~host_ok;
   assign slave_readdata    = rdata_q;
   assign idx_nxt           = idx_q + 32'd1;

   // Row and store addresses advance incrementally instead of multiplying i.
   always_comb begin
      state_d   = state_q;
      wbase_d   = wbase_q;
      inaddr_d  = inaddr_q;
      obase_d   = obase_q;
      len_d     = len_q;
      outcnt_d  = outcnt_q;
      idx_d     = idx_q;
      count_d   = count_q;
      rowaddr_d = rowaddr_q;
      memaddr_d = memaddr_q;
      result_d  = result_q;
      rdata_d   = rdata_q;
      rdpend_d  = rdpend_q;

      if (host_ok && slave_read) begin
         case (slave_address)
            CPU_START:  rdata_d = count_q;
            CPU_WBASE:  rdata_d = wbase_q;
            CPU_INADDR: rdata_d = inaddr_q;
            CPU_OBASE:  rdata_d = obase_q;
            CPU_LEN:    rdata_d = len_q;
            CPU_OUTCNT: rdata_d = outcnt_q;
            default:    rdata_d = '0;
         endcase
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (slave_write) begin
               case (slave_address)
                  CPU_START: begin
                     idx_d     = '0;
                     count_d   = '0;
                     result_d  = '0;
                     rowaddr_d = wbase_q;
                     memaddr_d = obase_q;
                     if (outcnt_q == '0)    state_d = ST_DONE;
                     else if (len_q == '0)  state_d = ST_STORE;
                     else                   state_d = ST_CFG_W;
                  end
                  CPU_WBASE:  wbase_d  = slave_writedata;
                  CPU_INADDR: inaddr_d = slave_writedata;
                  CPU_OBASE:  obase_d  = slave_writedata;
                  CPU_LEN:    len_d    = slave_writedata;
                  CPU_OUTCNT: outcnt_d = slave_writedata;
                  default: ;
               endcase
            end
         end
         ST_CFG_W: if (!dot_waitrequest) state_d = ST_CFG_V;
         ST_CFG_V: if (!dot_waitrequest) state_d = ST_CFG_L;
         ST_CFG_L: if (!dot_waitrequest) state_d = ST_GO;
         ST_GO: begin
            rdpend_d = 1'b0;
            if (!dot_waitrequest) state_d = ST_RES;
         end
         ST_RES: begin
            if (rdpend_q) begin
               result_d = dot_readdata;
               rdpend_d = 1'b0;
               state_d  = ST_STORE;
            end else if (!dot_waitrequest) begin
               rdpend_d = 1'b1;
            end
         end
         ST_STORE: begin
            if (!mem_waitrequest) begin
               count_d = count_q + 32'd1;
               state_d = ST_NEXT;
            end
         end
         ST_NEXT: begin
            idx_d     = idx_nxt;
            rowaddr_d = rowaddr_q + {len_q[29:0], 2'b00};
            memaddr_d = memaddr_q + 32'd4;
            if (idx_nxt < outcnt_q) state_d = (len_q == '0) ? ST_STORE : ST_CFG_W;
            else                    state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      dot_read      = 1'b0;
      dot_write     = 1'b0;
      dot_address   = DOT_CTRL;
      dot_writedata = '0;
      case (state_q)
         ST_CFG_W: begin dot_write = 1'b1; dot_address = DOT_WBASE; dot_writedata = rowaddr_q; end
         ST_CFG_V: begin dot_write = 1'b1; dot_address = DOT_VEC;   dot_writedata = inaddr_q;  end
         ST_CFG_L: begin dot_write = 1'b1; dot_address = DOT_LEN;   dot_writedata = len_q;     end
         ST_GO:    dot_write = 1'b1;
         ST_RES:   dot_read  = ~rdpend_q;
         default: ;
      endcase
   end

   assign mem_write   = (state_q == ST_STORE);
   assign mem_address = memaddr_q;
`ifdef LAYER_SCHED_RELU_EN
   assign mem_writedata = relu(result_q);
`else
   assign mem_writedata = result_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         wbase_q   <= '0;
         inaddr_q  <= '0;
         obase_q   <= '0;
         len_q     <= '0;
         outcnt_q  <= '0;
         idx_q     <= '0;
         count_q   <= '0;
         rowaddr_q <= '0;
         memaddr_q <= '0;
         result_q  <= '0;
         rdata_q   <= '0;
         rdpend_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         wbase_q   <= wbase_d;
         inaddr_q  <= inaddr_d;
         obase_q   <= obase_d;
         len_q     <= len_d;
         outcnt_q  <= outcnt_d;
         idx_q     <= idx_d;
         count_q   <= count_d;
         rowaddr_q <= rowaddr_d;
         memaddr_q <= memaddr_d;
         result_q  <= result_d;
         rdata_q   <= rdata_d;
         rdpend_q  <= rdpend_d;
      end
   end

endmodule

// File: tb/tb_layer_sched.sv
// Directed bench for layer_sched with a dot-engine/memory responder model;
// expectations follow LAYER_SCHED_RELU_EN when it is defined.
module tb_layer_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        slave_waitrequest;
   logic [3:0]  slave_address = '0;
   logic        slave_read = 1'b0;
   logic        slave_write = 1'b0;
   logic [31:0] slave_readdata;
   logic [31:0] slave_writedata = '0;
   logic [3:0]  dot_address;
   logic        dot_read, dot_write;
   logic [31:0] dot_writedata;
   logic [31:0] dot_readdata = '0;
   logic        dot_waitrequest;
   logic [31:0] mem_address;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic        mem_waitrequest;

`ifdef LAYER_SCHED_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   always #5 clk = ~clk;

   layer_sched dut (
      .clk(clk), .rst_n(rst_n),
      .slave_waitrequest(slave_waitrequest), .slave_address(slave_address),
      .slave_read(slave_read), .slave_write(slave_write),
      .slave_readdata(slave_readdata), .slave_writedata(slave_writedata),
      .dot_address(dot_address), .dot_read(dot_read), .dot_write(dot_write),
      .dot_writedata(dot_writedata), .dot_readdata(dot_readdata),
      .dot_waitrequest(dot_waitrequest),
      .mem_address(mem_address), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_waitrequest(mem_waitrequest)
   );

   int checks = 0;
   int errors = 0;

   // responder model
   bit          dot_stall = 1'b0, mem_stall = 1'b0;
   int          dcnt = 0, mcnt = 0;
   int          rd_idx = 0, rd_base = 0, res_len = 1;
   logic [31:0] res_tab [4];

   assign dot_waitrequest = (dot_read | dot_write) && dot_stall && (dcnt < 4);
   assign mem_waitrequest = mem_write && mem_stall && (mcnt < 2);

   always @(posedge clk) begin
      if (!rst_n) begin
         dcnt <= 0;
         mcnt <= 0;
      end else begin
         if (dot_read | dot_write) dcnt <= dot_waitrequest ? dcnt + 1 : 0;
         if (mem_write) mcnt <= mem_waitrequest ? mcnt + 1 : 0;
         if (dot_read && !dot_waitrequest) begin
            dot_readdata <= res_tab[(rd_idx - rd_base) % res_len];
            rd_idx <= rd_idx + 1;
         end
      end
   end

   // traffic monitor
   logic [31:0] wq[$], maq[$], mdq[$];
   int dacc = 0, dstall = 0, mstall = 0, sviol = 0, ohviol = 0;
   bit p_ds = 0, p_ms = 0, p_dr = 0, p_dw = 0;
   logic [3:0]  p_da = '0;
   logic [31:0] p_dd = '0, p_ma = '0, p_md = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         p_ds = 0;
         p_ms = 0;
      end else begin
         if ((dot_read && dot_write) || (dot_read && mem_write) || (dot_write && mem_write))
            ohviol++;
         if (p_ds && (dot_read !== p_dr || dot_write !== p_dw ||
                      dot_address !== p_da || dot_writedata !== p_dd)) sviol++;
         if (p_ms && (mem_write !== 1'b1 || mem_address !== p_ma || mem_writedata !== p_md))
            sviol++;
         if (dot_read | dot_write) begin
            if (dot_waitrequest) dstall++;
            else begin
               dacc++;
               if (dot_write && dot_address == 4'd2) wq.push_back(dot_writedata);
            end
         end
         if (mem_write) begin
            if (mem_waitrequest) mstall++;
            else begin
               maq.push_back(mem_address);
               mdq.push_back(mem_writedata);
            end
         end
         p_ds = (dot_read | dot_write) && dot_waitrequest;
         p_ms = mem_write && mem_waitrequest;
         p_dr = dot_read; p_dw = dot_write; p_da = dot_address; p_dd = dot_writedata;
         p_ma = mem_address; p_md = mem_writedata;
      end
   end

   function automatic logic [31:0] exp_store(input logic [31:0] v);
      return (RELU && v[31]) ? 32'h0 : v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
      int n;
      @(negedge clk);
      slave_address = a; slave_writedata = d; slave_write = 1'b1; n = 0;
      while (slave_waitrequest && n < 3000) begin @(negedge clk); n++; end
      chk("wr_timeout", 32'(n < 3000), 32'd1);
      @(posedge clk); #1;
      slave_write = 1'b0;
   endtask

   task automatic cpu_read(input logic [3:0] a, output logic [31:0] d, output int n);
      @(negedge clk);
      slave_address = a; slave_read = 1'b1; n = 0;
      while (slave_waitrequest && n < 3000) begin @(negedge clk); n++; end
      chk("rd_timeout", 32'(n < 3000), 32'd1);
      @(posedge clk); #1;
      d = slave_readdata;
      slave_read = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      int w, w0, m0, d0, ds0, ms0;
      logic [3:0]  ra [7];
      logic [31:0] rv [7];

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_waitreq", 32'(slave_waitrequest), 32'd1);
      chk("rst_strobes", 32'({dot_read, dot_write, mem_write}), 32'd0);
      chk("rst_memaddr", mem_address, 32'd0);
      chk("rst_dotdata", dot_writedata, 32'd0);
      chk("rst_rdata", slave_readdata, 32'd0);
      rst_n = 1'b1;
      #1 chk("idle_waitreq", 32'(slave_waitrequest), 32'd0);

      // basic layer N=2, M=3
      res_tab[0] = 32'd5; res_tab[1] = 32'hFFFF_FFFD; res_tab[2] = 32'd7; res_len = 3;
      cpu_write(4'd2, 32'h1000);
      cpu_write(4'd3, 32'h3000);
      cpu_write(4'd4, 32'h2000);
      cpu_write(4'd5, 32'd2);
      cpu_write(4'd6, 32'd3);
      rd_base = rd_idx; w0 = wq.size(); m0 = maq.size(); d0 = dacc;
      cpu_write(4'd0, 32'd0);
      cpu_read(4'd0, d, w);
      chk("basic_count", d, 32'd3);
      chk("basic_row0", wq[w0], 32'h1000);
      chk("basic_row1", wq[w0+1], 32'h1008);
      chk("basic_row2", wq[w0+2], 32'h1010);
      chk("basic_ma0", maq[m0], 32'h2000);
      chk("basic_md0", mdq[m0], exp_store(32'd5));
      chk("basic_ma1", maq[m0+1], 32'h2004);
      chk("basic_md1", mdq[m0+1], exp_store(32'hFFFF_FFFD));
      chk("basic_ma2", maq[m0+2], 32'h2008);
      chk("basic_md2", mdq[m0+2], exp_store(32'd7));
      chk("basic_memn", 32'(maq.size() - m0), 32'd3);
      chk("basic_dotn", 32'(dacc - d0), 32'd15);

      // register readback, including reserved offsets
      ra = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
      rv = '{32'h0, 32'h1000, 32'h3000, 32'h2000, 32'd2, 32'd3, 32'h0};
      for (int k = 0; k < 7; k++) begin
         cpu_read(ra[k], d, w);
         chk($sformatf("readback_%0d", ra[k]), d, rv[k]);
      end

      // stalls on every access
      dot_stall = 1'b1; mem_stall = 1'b1;
      rd_base = rd_idx; w0 = wq.size(); m0 = maq.size(); d0 = dacc; ds0 = dstall; ms0 = mstall;
      cpu_write(4'd0, 32'd0);
      cpu_read(4'd0, d, w);
      chk("stall_count", d, 32'd3);
      chk("stall_row1", wq[w0+1], 32'h1008);
      chk("stall_row2", wq[w0+2], 32'h1010);
      chk("stall_md1", mdq[m0+1], exp_store(32'hFFFF_FFFD));
      chk("stall_ma2", maq[m0+2], 32'h2008);
      chk("stall_dotn", 32'(dacc - d0), 32'd15);
      chk("stall_dotcyc", 32'(dstall - ds0), 32'd60);
      chk("stall_memcyc", 32'(mstall - ms0), 32'd6);
      dot_stall = 1'b0; mem_stall = 1'b0;

      // restart twice with identical configuration
      rd_base = rd_idx; w0 = wq.size(); m0 = maq.size(); d0 = dacc;
      cpu_write(4'd0, 32'd0);
      cpu_read(4'd0, d, w);
      chk("restart1_count", d, 32'd3);
      cpu_write(4'd0, 32'd0);
      cpu_read(4'd0, d, w);
      chk("restart2_count", d, 32'd3);
      chk("restart_memn", 32'(maq.size() - m0), 32'd6);
      chk("restart_dotn", 32'(dacc - d0), 32'd30);
      chk("restart_row", wq[w0+3], 32'h1000);
      chk("restart_ma", maq[m0+3], 32'h2000);

      // M = 0
      cpu_write(4'd6, 32'd0);
      m0 = maq.size(); d0 = dacc;
      cpu_write(4'd0, 32'd0);
      cpu_read(4'd0, d, w);
      chk("m0_count", d, 32'd0);
      chk("m0_traffic", 32'((maq.size() - m0) + (dacc - d0)), 32'd0);

      // N = 0, M = 2
      cpu_write(4'd5, 32'd0);
      cpu_write(4'd6, 32'd2);
      m0 = maq.size(); d0 = dacc;
      cpu_write(4'd0, 32'd0);
      cpu_read(4'd0, d, w);
      chk("n0_count", d, 32'd2);
      chk("n0_memn", 32'(maq.size() - m0), 32'd2);
      chk("n0_dotn", 32'(dacc - d0), 32'd0);
      chk("n0_ma1", maq[m0+1], 32'h2004);
      chk("n0_md0", mdq[m0], 32'd0);
      chk("n0_md1", mdq[m0+1], 32'd0);

      // negative result, ReLU dependent
      cpu_write(4'd5, 32'd1);
      cpu_write(4'd6, 32'd1);
      res_tab[0] = 32'hFFFF_FFFC; res_len = 1; rd_base = rd_idx;
      m0 = maq.size();
      cpu_write(4'd0, 32'd0);
      cpu_read(4'd0, d, w);
      chk("relu_count", d, 32'd1);
      chk("relu_md", mdq[m0], RELU ? 32'h0 : 32'hFFFF_FFFC);

      // reset during STORE of i=1
      cpu_write(4'd5, 32'd2);
      cpu_write(4'd6, 32'd3);
      res_tab[0] = 32'd5; res_tab[1] = 32'hFFFF_FFFD; res_tab[2] = 32'd7; res_len = 3;
      rd_base = rd_idx; mem_stall = 1'b1;
      cpu_write(4'd0, 32'd0);
      w = 0;
      while (!(mem_write && mem_address == 32'h2004) && w < 500) begin @(negedge clk); w++; end
      chk("mid_reached", 32'(w < 500), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_strobes", 32'({dot_read, dot_write, mem_write}), 32'd0);
      chk("mid_waitreq", 32'(slave_waitrequest), 32'd1);
      chk("mid_memaddr", mem_address, 32'd0);
      mem_stall = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m0 = maq.size(); d0 = dacc;
      cpu_read(4'd5, d, w);
      chk("postrst_len", d, 32'd0);
      chk("postrst_nowait", 32'(w), 32'd0);
      cpu_read(4'd0, d, w);
      chk("postrst_count", d, 32'd0);
      repeat (10) @(negedge clk);
      chk("postrst_noresume", 32'((maq.size() - m0) + (dacc - d0)), 32'd0);

      chk("stall_stable", 32'(sviol), 32'd0);
      chk("strobe_onehot", 32'(ohviol), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
